spi_master_burst: RTL and testbench

- Second-generation SPI master that moves multi-word bursts under one chip-select assertion.
- SPI mode (CPOL/CPHA), bit order, SCLK divider and target slave are runtime inputs, latched per burst.
- Supports NUM_CS slave selects and programmable CS lead/trail delays.
- Sits between a host word stream (valid/ready) and the board SPI pins, alongside the existing single-word controller.

---
 rtl/spi_master_burst_if.sv | 27 ++
 rtl/spi_master_burst.sv | 198 +++++++++++++++++++
 tb/tb_spi_master_burst.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_burst_if.sv
// spi_master_burst_if: host word-stream bundle for spi_master_burst.
//   i_tx_valid/i_tx_data/i_tx_last : host -> controller tx word and burst marker
//   o_tx_ready                     : controller -> host, word can be accepted
//   o_rx_valid/o_rx_data/o_rx_last : controller -> host, received word pulse
// Signal names carry the controller's point of view (i_ = into the controller).
// The host uses the master modport and the controller uses the slave modport.
interface spi_master_burst_if #(
    parameter int DATA_BW = 8
);
    logic               i_tx_valid;
    logic [DATA_BW-1:0] i_tx_data;
    logic               i_tx_last;
    logic               o_tx_ready;
    logic               o_rx_valid;
    logic [DATA_BW-1:0] o_rx_data;
    logic               o_rx_last;

    modport master (
        output i_tx_valid, i_tx_data, i_tx_last,
        input  o_tx_ready, o_rx_valid, o_rx_data, o_rx_last
    );

    modport slave (
        input  i_tx_valid, i_tx_data, i_tx_last,
        output o_tx_ready, o_rx_valid, o_rx_data, o_rx_last
    );
endinterface

// File: rtl/spi_master_burst.sv
// spi_master_burst: SPI master that moves multi-word bursts under one CS.
//   clk, rstn        : clock, asynchronous active-low reset
//   i_cpol/i_cpha    : SPI mode, latched at burst start
//   i_lsb_first      : bit order, latched at burst start
//   i_clk_half       : clk cycles per SCLK half-period (0 behaves as 1)
//   i_cs_sel         : target slave; values >= NUM_CS select nobody
//   bus (slave)      : tx word stream in, rx word pulses out
//   o_busy           : high from burst accept until CS is released
//   spi_sclk/mosi/cs_n, spi_miso : board pins, outputs all registered
module spi_master_burst #(
    parameter  int DATA_BW  = 8,
    parameter  int NUM_CS   = 4,
    parameter  int DIV_BW   = 8,
    parameter  int CS_LEAD  = 2,
    parameter  int CS_TRAIL = 2,
    localparam int CS_BW    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_cpol,
    input  logic              i_cpha,
    input  logic              i_lsb_first,
    input  logic [DIV_BW-1:0] i_clk_half,
    input  logic [CS_BW-1:0]  i_cs_sel,
    spi_master_burst_if.slave bus,
    output logic              o_busy,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_CS-1:0] spi_cs_n
);
    localparam int EDGE_BW = $clog2(2*DATA_BW) + 1;
    localparam int CNT_MAX = (CS_LEAD > CS_TRAIL) ? CS_LEAD : CS_TRAIL;
    localparam int CNT_BW  = $clog2(CNT_MAX) + 1;
    localparam logic [EDGE_BW-1:0] LAST_EDGE = EDGE_BW'(2*DATA_BW - 1);
    localparam logic [CNT_BW-1:0]  LEAD_LD   = CNT_BW'(CS_LEAD - 1);
    localparam logic [CNT_BW-1:0]  TRAIL_LD  = CNT_BW'(CS_TRAIL - 1);

    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_XFER, S_WAIT, S_TRAIL} state_t;

    state_t              r_state;
    logic                r_cpha, r_lsb, r_last;
    logic [DIV_BW-1:0]   r_half, r_div;
    logic [CNT_BW-1:0]   r_cnt;
    logic [EDGE_BW-1:0]  r_edge;
    logic [DATA_BW-1:0]  r_tx_sh, r_rx_sh, r_rx_data;
    logic                r_sclk, r_mosi, r_busy, r_ready, r_rx_valid, r_rx_last;
    logic [NUM_CS-1:0]   r_cs_n;

    logic                w_accept, w_edge, w_sample;
    logic                w_ld_lsb, w_ld_cpha, w_ld_bit, w_tx_bit;
    logic [DIV_BW-1:0]   w_half_m1;
    logic [DATA_BW-1:0]  w_ld_shift, w_tx_shift, w_rx_in, w_rx_word;
    logic [NUM_CS-1:0]   w_cs_dec;

    assign w_accept  = bus.i_tx_valid & r_ready;
    assign w_half_m1 = (r_half == '0) ? '0 : r_half - 1'b1;

    // The first SCLK edge is issued from LEAD itself so that CS-to-first-edge
    // is exactly CS_LEAD cycles; every later edge comes from the divider.
    assign w_edge = ((r_state == S_LEAD) && (r_cnt == '0)) ||
                    ((r_state == S_XFER) && (r_div == w_half_m1));

    // Even edge index = leading edge. CPHA=0 samples on leading, CPHA=1 on
    // trailing; the opposite edge shifts MOSI.
    assign w_sample = r_cpha ^ ~r_edge[0];

    // Mode/order come from the pins on an IDLE accept, from the latched
    // copy on a WAIT accept.
    assign w_ld_lsb   = (r_state == S_IDLE) ? i_lsb_first : r_lsb;
    assign w_ld_cpha  = (r_state == S_IDLE) ? i_cpha      : r_cpha;
    assign w_ld_bit   = w_ld_lsb ? bus.i_tx_data[0] : bus.i_tx_data[DATA_BW-1];
    assign w_ld_shift = w_ld_lsb ? (bus.i_tx_data >> 1) : (bus.i_tx_data << 1);
    assign w_tx_bit   = r_lsb ? r_tx_sh[0] : r_tx_sh[DATA_BW-1];
    assign w_tx_shift = r_lsb ? (r_tx_sh >> 1) : (r_tx_sh << 1);

    // LSB-first fills from the top so the word ends up bit-aligned.
    assign w_rx_in   = r_lsb ? {spi_miso, r_rx_sh[DATA_BW-1:1]}
                             : {r_rx_sh[DATA_BW-2:0], spi_miso};
    assign w_rx_word = w_sample ? w_rx_in : r_rx_sh;

    always_comb begin
        w_cs_dec = '1;
        for (int k = 0; k < NUM_CS; k++)
            if (i_cs_sel == CS_BW'(k)) w_cs_dec[k] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
            r_last     <= 1'b0;
            r_half     <= '0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_edge     <= '0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_last  <= 1'b0;
            r_cs_n     <= '1;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_last  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_sclk  <= i_cpol;
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_cpha  <= i_cpha;
                        r_lsb   <= i_lsb_first;
                        r_half  <= i_clk_half;
                        r_cs_n  <= w_cs_dec;
                        r_busy  <= 1'b1;
                        r_cnt   <= LEAD_LD;
                        r_state <= S_LEAD;
                    end
                end
                S_LEAD: begin
                    if (r_cnt == '0) begin
                        r_state <= S_XFER;
                        r_div   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_XFER: begin
                    if (r_div == w_half_m1) r_div <= '0;
                    else                    r_div <= r_div + 1'b1;
                end
                S_WAIT: begin
                    if (w_accept) r_state <= S_XFER;
                end
                S_TRAIL: begin
                    if (r_cnt == '0) begin
                        r_cs_n  <= '1;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Per-word load, shared by IDLE and WAIT accepts.
            if (w_accept) begin
                r_last  <= bus.i_tx_last;
                r_edge  <= '0;
                r_div   <= '0;
                r_rx_sh <= '0;
                r_ready <= 1'b0;
                if (!w_ld_cpha) begin
                    r_mosi  <= w_ld_bit;
                    r_tx_sh <= w_ld_shift;
                end else begin
                    r_tx_sh <= bus.i_tx_data;
                end
            end

            if (w_edge) begin
                r_sclk <= ~r_sclk;
                r_edge <= r_edge + 1'b1;
                if (w_sample) begin
                    r_rx_sh <= w_rx_in;
                end else begin
                    r_mosi  <= w_tx_bit;
                    r_tx_sh <= w_tx_shift;
                end
                if (r_edge == LAST_EDGE) begin
                    r_rx_valid <= 1'b1;
                    r_rx_data  <= w_rx_word;
                    r_rx_last  <= r_last;
                    r_cnt      <= TRAIL_LD;
                    r_ready    <= ~r_last;
                    r_state    <= r_last ? S_TRAIL : S_WAIT;
                end
            end
        end
    end

    assign bus.o_tx_ready = r_ready;
    assign bus.o_rx_valid = r_rx_valid;
    assign bus.o_rx_data  = r_rx_data;
    assign bus.o_rx_last  = r_rx_last;
    assign o_busy         = r_busy;
    assign spi_sclk       = r_sclk;
    assign spi_mosi       = r_mosi;
    assign spi_cs_n       = r_cs_n;
endmodule

// File: tb/tb_spi_master_burst.sv
// tb_spi_master_burst: scoreboard bench for spi_master_burst.
// Stimulus pushes expected rx words and expected MOSI words into queues;
// independent monitors rebuild words from the pins and the rx stream.
module tb_spi_master_burst;
    localparam int DW = 8, NCS = 4, DIVW = 8, LEAD = 2, TRAIL = 2;

    logic            clk = 1'b0, rstn = 1'b0;
    logic            cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;
    logic [DIVW-1:0] half = 8'd1;
    logic [1:0]      cs_sel = 2'd0;
    logic            busy, sclk, mosi, miso;
    logic [NCS-1:0]  cs_n;

    spi_master_burst_if #(.DATA_BW(DW)) bus ();

    spi_master_burst #(.DATA_BW(DW), .NUM_CS(NCS), .DIV_BW(DIVW),
                       .CS_LEAD(LEAD), .CS_TRAIL(TRAIL)) dut (
        .clk(clk), .rstn(rstn), .i_cpol(cpol), .i_cpha(cpha), .i_lsb_first(lsb),
        .i_clk_half(half), .i_cs_sel(cs_sel), .bus(bus), .o_busy(busy),
        .spi_sclk(sclk), .spi_mosi(mosi), .spi_miso(miso), .spi_cs_n(cs_n)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: burst configuration as the host issued it.
    logic m_cpol = 0, m_cpha = 0, m_lsb = 0;
    int   m_half = 1, m_sel = 0;
    logic [8:0] q_rx[$];   // {last, data}
    logic [7:0] q_tx[$];   // word expected on MOSI
    logic use_slave = 0;
    logic [7:0] slave_word = 8'h3C, s_reg = 8'h3C;

    function automatic logic [NCS-1:0] exp_cs(input int sel);
        logic [NCS-1:0] r = '1;
        if (sel < NCS) r[sel] = 1'b0;
        return r;
    endfunction

    assign miso = use_slave ? s_reg[7] : mosi;

    // Pin monitor: capture MOSI on the sampling edge of the burst's mode.
    int bitcnt = 0;
    logic [7:0] acc = 0;
    logic prev_sclk = 0;
    longint last_samp = 0;
    always @(negedge clk) begin
        if (!rstn) begin
            bitcnt = 0;
        end else begin
            if (busy && sclk != prev_sclk) begin
                if (sclk == (m_cpol ^ ~m_cpha)) begin
                    check("cs_n_during_xfer", cs_n, exp_cs(m_sel));
                    if (bitcnt > 0)
                        check("sclk_period", cyc - last_samp, 2 * ((m_half == 0) ? 1 : m_half));
                    last_samp = cyc;
                    acc = m_lsb ? {mosi, acc[7:1]} : {acc[6:0], mosi};
                    bitcnt++;
                    if (bitcnt == 8) begin
                        bitcnt = 0;
                        if (q_tx.size() == 0) check("mosi_unexpected_word", 1, 0);
                        else check("mosi_word", acc, q_tx.pop_front());
                    end
                end else if (use_slave) begin
                    s_reg = s_reg << 1;
                end
            end
            if (!busy) s_reg = slave_word;
        end
        prev_sclk = sclk;
    end

    // Rx monitor / scoreboard.
    logic [8:0] rx_e;
    always @(negedge clk) begin
        if (rstn && bus.o_rx_valid) begin
            if (q_rx.size() == 0) check("rx_unexpected", 1, 0);
            else begin
                rx_e = q_rx.pop_front();
                check("rx_data", bus.o_rx_data, rx_e[7:0]);
                check("rx_last", bus.o_rx_last, rx_e[8]);
            end
        end
    end

    task automatic cfg(input logic p, input logic a, input logic l,
                       input logic [7:0] h, input logic [1:0] s);
        cpol = p; cpha = a; lsb = l; half = h; cs_sel = s;
        m_cpol = p; m_cpha = a; m_lsb = l; m_half = h; m_sel = s;
        repeat (3) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic l, input logic [7:0] rx_exp);
        int t = 0;
        bus.i_tx_data = d; bus.i_tx_last = l; bus.i_tx_valid = 1'b1;
        while (!bus.o_tx_ready && t < 20000) begin @(negedge clk); t++; end
        if (t >= 20000) begin
            check("tx_ready_timeout", 0, 1);
            bus.i_tx_valid = 1'b0;
            return;
        end
        q_tx.push_back(d);
        q_rx.push_back({l, rx_exp});
        @(posedge clk); #1;
        bus.i_tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 20000) begin @(negedge clk); t++; end
        check("busy_cleared", busy, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!bus.o_tx_ready && t < 20000) begin @(negedge clk); t++; end
        check("ready_in_wait", bus.o_tx_ready, 1);
    endtask

    initial begin
        int t;
        longint c0;
        logic [7:0] d;
        int len;
        bus.i_tx_valid = 1'b0; bus.i_tx_data = '0; bus.i_tx_last = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_tx_ready", bus.o_tx_ready, 0);
        check("rst_rx_valid", bus.o_rx_valid, 0);
        check("rst_rx_data", bus.o_rx_data, 0);
        check("rst_rx_last", bus.o_rx_last, 0);
        check("rst_busy", busy, 0);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_cs_n", cs_n, 4'hF);
        rstn = 1'b1;
        #1 check("ready_first_cycle", bus.o_tx_ready, 0);
        @(posedge clk); #1 check("ready_after_first", bus.o_tx_ready, 1);

        // Mode 0 single word to slave 1, slave answers 0x3C.
        use_slave = 1;
        cfg(0, 0, 0, 8'd2, 2'd1);
        send(8'hA5, 1'b1, 8'h3C);
        c0 = cyc;
        t = 0;
        while (sclk == m_cpol && t < 100) begin @(negedge clk); t++; end
        check("cs_lead_cycles", cyc - c0, LEAD);
        t = 0;
        while (!bus.o_rx_valid && t < 500) begin @(negedge clk); t++; end
        t = 0;
        while (cs_n != 4'hF && t < 100) begin @(negedge clk); t++; end
        check("cs_trail_cycles", t, TRAIL);
        wait_idle();
        use_slave = 0;

        // Mode 3 three-word burst, loopback; SCLK idles high in WAIT.
        cfg(1, 1, 0, 8'd1, 2'd0);
        send(8'h01, 1'b0, 8'h01);
        wait_ready();
        check("wait_sclk_cpol", sclk, 1);
        check("wait_cs_low", cs_n, exp_cs(0));
        send(8'h80, 1'b0, 8'h80);
        wait_ready();
        check("wait_sclk_cpol", sclk, 1);
        check("wait_cs_low", cs_n, exp_cs(0));
        send(8'hFF, 1'b1, 8'hFF);
        wait_idle();

        // Modes 1 and 2, LSB first.
        cfg(0, 1, 1, 8'd2, 2'd2);
        send(8'h01, 1'b1, 8'h01);
        wait_idle();
        cfg(1, 0, 1, 8'd2, 2'd3);
        send(8'h01, 1'b1, 8'h01);
        wait_idle();

        // WAIT stall with config pins toggling.
        cfg(0, 0, 0, 8'd2, 2'd2);
        send(8'hC3, 1'b0, 8'hC3);
        wait_ready();
        for (int i = 0; i < 50; i++) begin
            cpol = ~cpol; cs_sel = cs_sel + 2'd1; lsb = ~lsb; cpha = ~cpha;
            @(negedge clk);
            if (i % 10 == 9) begin
                check("stall_sclk", sclk, m_cpol);
                check("stall_ready", bus.o_tx_ready, 1);
                check("stall_cs", cs_n, exp_cs(m_sel));
            end
        end
        send(8'h96, 1'b1, 8'h96);
        wait_idle();

        // Divider extremes.
        cfg(0, 0, 0, 8'd0, 2'd0);
        d = 8'($urandom);
        send(d, 1'b1, d);
        wait_idle();
        cfg(1, 1, 1, 8'd255, 2'd1);
        d = 8'($urandom);
        send(d, 1'b1, d);
        wait_idle();

        // Randomized bursts.
        for (int b = 0; b < 15; b++) begin
            cfg(1'($urandom), 1'($urandom), 1'($urandom),
                8'($urandom_range(0, 3)), 2'($urandom));
            len = $urandom_range(1, 3);
            for (int w = 0; w < len; w++) begin
                d = 8'($urandom);
                send(d, (w == len - 1), d);
            end
            wait_idle();
        end

        // Reset halfway through word 2.
        cfg(0, 0, 0, 8'd2, 2'd1);
        send(8'h5C, 1'b0, 8'h5C);
        send(8'hE7, 1'b1, 8'hE7);
        repeat (16) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("abort_cs_n", cs_n, 4'hF);
        check("abort_busy", busy, 0);
        check("abort_rx_valid", bus.o_rx_valid, 0);
        check("abort_sclk", sclk, 0);
        q_rx.delete();
        q_tx.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        cfg(1, 0, 0, 8'd1, 2'd3);
        send(8'h5A, 1'b1, 8'h5A);
        wait_idle();

        check("rx_queue_drained", q_rx.size(), 0);
        check("tx_queue_drained", q_tx.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end
endmodule
